// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiplier/divider.
package mult_div_pkg;
    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? -v : v;
    endfunction
endpackage

// File: rtl/mult_div_if.sv
// Operand/result bundle between the execute stage and mult_div.
interface mult_div_if
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY
    );
    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/mult_div_step.sv
// One iteration of the shared datapath: radix-2 Booth step or restoring
// divide step on the {hi, lo} accumulator pair.
module mult_div_step
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             op_div_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             qm1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             qm1_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] diff;

    always_comb begin
        unique case ({lo_i[0], qm1_i})
            2'b01:   sum = hi_i + m_i;
            2'b10:   sum = hi_i - m_i;
            default: sum = hi_i;
        endcase
        // hi holds the remainder, lo shifts the dividend out and the quotient in
        rsh  = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
        diff = rsh - m_i;

        if (op_div_i) begin
            qm1_o = qm1_i;
            if (!diff[WIDTH]) begin
                hi_o = diff;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rsh;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o  = {sum[WIDTH], sum[WIDTH:1]};
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
            qm1_o = lo_i[0];
        end
    end
endmodule

// File: rtl/mult_div.sv
// Fixed 33-cycle signed multiply/divide unit: FSM, operand registers and
// result registers around a single shared iteration step.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             clock,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    input  logic             reset_n
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_MULT = MULT;
    localparam logic [1:0] ST_DIV  = DIV;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d, m_q, m_d;
    logic [WIDTH-1:0] lo_q, lo_d, res_q, res_d;
    logic             qm1_q, qm1_d, op_div_q, op_div_d;
    logic             neg_q, neg_d, bzero_q, bzero_d;
    logic             exc_q, exc_d, rdy_q, rdy_d;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             step_qm1;
    logic [WIDTH:0]   prod_top;

    mult_div_step #(.WIDTH(WIDTH)) u_step (
        .op_div_i (op_div_q),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .qm1_i    (qm1_q),
        .m_i      (m_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo),
        .qm1_o    (step_qm1)
    );

    // product[63:31]; the product fits in 32 bits only if these all match
    assign prod_top = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        m_d      = m_q;
        op_div_d = op_div_q;
        neg_d    = neg_q;
        bzero_d  = bzero_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        if (ctrl_MULT || ctrl_DIV) begin
            op_div_d = !ctrl_MULT;
            state_d  = ctrl_MULT ? ST_MULT : ST_DIV;
            cnt_d    = '0;
            hi_d     = '0;
            qm1_d    = 1'b0;
            neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            bzero_d  = (data_operandB == '0);
            if (ctrl_MULT) begin
                m_d  = {data_operandA[WIDTH-1], data_operandA};
                lo_d = data_operandB;
            end else begin
                m_d  = {1'b0, md_abs(data_operandB)};
                lo_d = md_abs(data_operandA);
            end
        end else begin
            unique case (state_q)
                ST_MULT, ST_DIV: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    qm1_d = step_qm1;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH-1)) state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    rdy_d   = 1'b1;
                    if (!op_div_q) begin
                        res_d = lo_q;
                        exc_d = !((&prod_top) || !(|prod_top));
                    end else if (bzero_q) begin
                        res_d = '0;
                        exc_d = 1'b1;
                    end else begin
                        // a positive quotient with the top bit set is only -2^31 / -1
                        res_d = neg_q ? -lo_q : lo_q;
                        exc_d = !neg_q && lo_q[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            m_q      <= '0;
            op_div_q <= 1'b0;
            neg_q    <= 1'b0;
            bzero_q  <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            m_q      <= m_d;
            op_div_q <= op_div_d;
            neg_q    <= neg_d;
            bzero_q  <= bzero_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_mult_div.sv
// Directed-vector bench for mult_div with hand-computed expected results.
module tb_mult_div;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    mult_div_if #(.WIDTH(32)) bus ();

    always #5 clock = ~clock;

    mult_div #(.WIDTH(32)) dut (
        .data_operandA  (bus.data_operandA),
        .data_operandB  (bus.data_operandB),
        .ctrl_MULT      (bus.ctrl_MULT),
        .ctrl_DIV       (bus.ctrl_DIV),
        .clock          (clock),
        .data_result    (bus.data_result),
        .data_exception (bus.data_exception),
        .data_resultRDY (bus.data_resultRDY),
        .reset_n        (reset_n)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        @(negedge clock);
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'h1234_5678;
    endtask

    task automatic wait_rdy(output int cyc);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!bus.data_resultRDY && cyc < 60);
    endtask

    task automatic run(input string tag, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ee);
        int cyc;
        start(m, d, a, b);
        wait_rdy(cyc);
        chk({tag, "_lat"}, 32'(cyc), 32'd33);
        chk({tag, "_res"}, bus.data_result, er);
        chk({tag, "_exc"}, 32'(bus.data_exception), 32'(ee));
        repeat (3) @(negedge clock);
        chk({tag, "_rdy_low"}, 32'(bus.data_resultRDY), 32'd0);
        chk({tag, "_hold"}, bus.data_result, er);
    endtask

    initial begin
        int pulses, first, cyc;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_res", bus.data_result, 32'd0);
        chk("rst_exc", 32'(bus.data_exception), 32'd0);
        chk("rst_rdy", 32'(bus.data_resultRDY), 32'd0);
        reset_n = 1'b1;

        run("mul_7x-6",   1, 0, 32'd7,        32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0);
        run("mul_ovf",    1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run("mul_min",    1, 0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0);
        run("both_high",  1, 1, 32'd6,        32'd3,        32'd18,        1'b0);
        run("div_-7/2",   0, 1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
        run("div_100/-10",0, 1, 32'd100,      32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
        run("div_by0",    0, 1, 32'd5,        32'd0,        32'd0,         1'b1);
        run("div_minneg1",0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        // restart a multiply with a divide five cycles in
        start(1, 0, 32'd3, 32'd4);
        repeat (4) @(negedge clock);
        start(0, 1, 32'd20, 32'd4);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (i == 10) chk("abort_keep_prev", bus.data_result, 32'h8000_0000);
            if (bus.data_resultRDY) begin
                pulses++;
                if (first == 0) begin
                    first = i;
                    chk("abort_res", bus.data_result, 32'd5);
                    chk("abort_exc", 32'(bus.data_exception), 32'd0);
                end
            end
        end
        chk("abort_pulses", 32'(pulses), 32'd1);
        chk("abort_lat", 32'(first), 32'd33);

        // reset in the middle of a multiply
        start(1, 0, 32'd7, 32'd7);
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midrst_res", bus.data_result, 32'd0);
        chk("midrst_exc", 32'(bus.data_exception), 32'd0);
        chk("midrst_rdy", 32'(bus.data_resultRDY), 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.data_resultRDY) pulses++;
        end
        chk("midrst_no_rdy", 32'(pulses), 32'd0);
        run("mul_9x9", 1, 0, 32'd9, 32'd9, 32'd81, 1'b0);

        cyc = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
